// File: rtl/if_fetch_unit_if.sv
// Handshake bundle tying the fetch unit to the PC stage, instruction memory and decode.
// The slave modport is the fetch unit's view; master is the surrounding pipeline/memory.
interface if_fetch_unit_if;
    logic        pc_valid_i;
    logic [31:0] pc_i;
    logic        pc_ready_o;
    logic        flush_i;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_gnt_i;
    logic        imem_rvalid_i;
    logic [31:0] imem_rdata_i;
    logic        inst_valid_o;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_ready_i;
    logic        halted_o;

    modport slave (
        input  pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        output pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, halted_o
    );

    modport master (
        output pc_valid_i, pc_i, flush_i, imem_gnt_i, imem_rvalid_i, imem_rdata_i, inst_ready_i,
        input  pc_ready_o, imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, halted_o
    );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch: one outstanding imem read per accepted PC, results queued with their PC
// for decode; supports flush on redirect and a sticky halt after the halt address returns.
module if_fetch_unit #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] HALT_ADDR = 32'd248
) (
    input  logic           clk_i,
    input  logic           rst_i,
    if_fetch_unit_if.slave bus
);
    localparam int unsigned      PTR_W    = $clog2(DEPTH);
    localparam int unsigned      CNT_W    = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DRAIN = 3'd3,
        HALT  = 3'd4
    } state_e;

    state_e           state_q;
    logic [31:0]      addr_q;
    logic             halt_hit_q;
    logic             req_q;
    logic             halted_q;
    logic [63:0]      fifo_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [31:0]      pc_aligned_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             not_empty_s;

    assign pc_aligned_s     = bus.pc_i & 32'hFFFF_FFFC;
    assign not_empty_s      = (count_q != {CNT_W{1'b0}});
    assign bus.pc_ready_o   = (state_q == IDLE) && !rst_i && !bus.flush_i && (count_q < FULL_CNT);
    assign accept_s         = bus.pc_valid_i && bus.pc_ready_o;
    // A response arriving together with a flush is dropped rather than queued.
    assign push_s           = (state_q == WAIT) && bus.imem_rvalid_i && !bus.flush_i;
    assign pop_s            = not_empty_s && bus.inst_ready_i;

    assign bus.imem_req_o   = req_q;
    assign bus.imem_addr_o  = addr_q;
    assign bus.halted_o     = halted_q;
    assign bus.inst_valid_o = not_empty_s;
    assign bus.inst_o       = not_empty_s ? fifo_q[rd_ptr_q][31:0]  : 32'd0;
    assign bus.inst_pc_o    = not_empty_s ? fifo_q[rd_ptr_q][63:32] : 32'd0;

    // Fetch sequencing: accept a PC, hold the request until granted, then await data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            addr_q     <= 32'd0;
            halt_hit_q <= 1'b0;
            req_q      <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept_s) begin
                        addr_q     <= pc_aligned_s;
                        halt_hit_q <= (pc_aligned_s == HALT_ADDR);
                        req_q      <= 1'b1;
                        state_q    <= REQ;
                    end
                end
                REQ: begin
                    if (bus.flush_i) begin
                        req_q   <= 1'b0;
                        state_q <= bus.imem_gnt_i ? DRAIN : IDLE;
                    end else if (bus.imem_gnt_i) begin
                        req_q   <= 1'b0;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (bus.imem_rvalid_i) begin
                        if (!bus.flush_i && halt_hit_q) begin
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end else begin
                            state_q  <= IDLE;
                        end
                    end else if (bus.flush_i) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (bus.imem_rvalid_i && !bus.flush_i) begin
                        state_q <= IDLE;
                    end
                end
                HALT: begin
                    state_q <= HALT;
                end
                default: begin
                    state_q  <= IDLE;
                    req_q    <= 1'b0;
                    halted_q <= 1'b0;
                end
            endcase
        end
    end

    // FIFO pointer/occupancy next state; flush clears everything including same-cycle push/pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (bus.flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_s, pop_s})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO control registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // FIFO storage; contents are only observed while occupancy is non-zero.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            fifo_q[wr_ptr_q] <= {addr_q, bus.imem_rdata_i};
        end
    end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: transaction-level reference model plus an imem responder,
// a halt-match vector table, directed corner sequences and a randomized phase.
module tb_if_fetch_unit;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] HALT  = 32'd248;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] exp_pc;
        logic        exp_halt;
    } vec_t;

    logic clk_i = 1'b0;
    logic rst_i;
    if_fetch_unit_if bus();

    if_fetch_unit #(.DEPTH(DEPTH), .HALT_ADDR(HALT)) dut (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    int errors = 0;
    int checks = 0;

    // reference model: what decode should see, and what is in flight
    ent_t        exp_q[$];
    logic [31:0] infl_pc = 32'd0;
    bit          infl_v = 1'b0, infl_gnt = 1'b0, drain_m = 1'b0, halt_m = 1'b0;
    // memory responder
    bit          rb_busy = 1'b0;
    int          rb_rv = 0, gw = 0, gnt_dly = 0, rv_dly = 0;
    logic [31:0] rb_addr = 32'd0;
    // observations from the DUT side
    bit          last_acc = 1'b0;
    int          dut_pops = 0, dut_accs = 0;
    logic [31:0] last_pop_pc = 32'd0, last_pop_data = 32'd0;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic int pick(input int d);
        return (d < 0) ? int'($urandom_range(2, 0)) : d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_bound(input string name);
        checks++;
        errors++;
        $display("FAIL %s: got no event, expected one within the cycle bound", name);
    endtask

    // One clock: compare at negedge, advance model at the edge, drive memory after it.
    task automatic step();
        logic exp_rdy, exp_req, rv, gn;
        ent_t e;
        @(negedge clk_i);
        exp_rdy = !bus.flush_i && !halt_m && !infl_v && !drain_m && (exp_q.size() < DEPTH);
        exp_req = infl_v && !infl_gnt;
        if (!rst_i) begin
            chk("pc_ready", 32'(bus.pc_ready_o), 32'(exp_rdy));
            chk("imem_req", 32'(bus.imem_req_o), 32'(exp_req));
            if (exp_req) chk("imem_addr", bus.imem_addr_o, infl_pc);
            chk("inst_valid", 32'(bus.inst_valid_o), 32'(exp_q.size() != 0));
            if (exp_q.size() != 0) begin
                chk("inst", bus.inst_o, exp_q[0].data);
                chk("inst_pc", bus.inst_pc_o, exp_q[0].pc);
            end
            chk("halted", 32'(bus.halted_o), 32'(halt_m));
        end
        last_acc = !rst_i && bus.pc_valid_i && bus.pc_ready_o;
        if (last_acc) dut_accs++;
        if (!rst_i && !bus.flush_i && bus.inst_valid_o && bus.inst_ready_i) begin
            dut_pops++;
            last_pop_pc   = bus.inst_pc_o;
            last_pop_data = bus.inst_o;
        end
        rv = bus.imem_rvalid_i;
        gn = bus.imem_gnt_i && exp_req;
        if (rst_i) begin
            exp_q.delete();
            infl_v = 1'b0; infl_gnt = 1'b0; drain_m = 1'b0; halt_m = 1'b0;
        end else if (bus.flush_i) begin
            exp_q.delete();
            if (infl_v && ((infl_gnt && !rv) || (!infl_gnt && gn))) drain_m = 1'b1;
            infl_v = 1'b0;
        end else begin
            if (exp_q.size() != 0 && bus.inst_ready_i) void'(exp_q.pop_front());
            if (drain_m && rv) begin
                drain_m = 1'b0;
            end else if (infl_v && infl_gnt && rv) begin
                e.pc = infl_pc;
                e.data = memf(infl_pc);
                exp_q.push_back(e);
                if (infl_pc == HALT) halt_m = 1'b1;
                infl_v = 1'b0;
            end
            if (gn) infl_gnt = 1'b1;
            if (bus.pc_valid_i && exp_rdy) begin
                infl_v = 1'b1;
                infl_gnt = 1'b0;
                infl_pc = bus.pc_i & 32'hFFFF_FFFC;
            end
        end
        @(posedge clk_i);
        #1;
        bus.imem_gnt_i = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i = $urandom();
        if (rst_i) begin
            rb_busy = 1'b0;
            gw = 0;
        end else if (rb_busy) begin
            if (rb_rv == 0) begin
                bus.imem_rvalid_i = 1'b1;
                bus.imem_rdata_i = memf(rb_addr);
                rb_busy = 1'b0;
            end else begin
                rb_rv--;
            end
        end else if (bus.imem_req_o) begin
            if (gw == 0) begin
                bus.imem_gnt_i = 1'b1;
                rb_addr = bus.imem_addr_o;
                rb_busy = 1'b1;
                rb_rv = pick(rv_dly);
                gw = pick(gnt_dly);
            end else begin
                gw--;
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic send_pc(input logic [31:0] pc);
        int n = 0;
        bus.pc_valid_i = 1'b1;
        bus.pc_i = pc;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        bus.pc_valid_i = 1'b0;
        if (!last_acc) fail_bound("send_pc");
    endtask

    task automatic wait_rvalid(input string name);
        int n = 0;
        while (!bus.imem_rvalid_i && n < 20) begin
            step();
            n++;
        end
        if (!bus.imem_rvalid_i) fail_bound(name);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        bus.flush_i = 1'b0;
        bus.pc_valid_i = 1'b0;
        gnt_dly = 0;
        rv_dly = 0;
        step();
        step();
        chk("rst_pc_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req_o), 32'd0);
        chk("rst_imem_addr", bus.imem_addr_o, 32'd0);
        chk("rst_inst_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("rst_inst", bus.inst_o, 32'd0);
        chk("rst_inst_pc", bus.inst_pc_o, 32'd0);
        chk("rst_halted", 32'(bus.halted_o), 32'd0);
        rst_i = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish, expected finish before 500us");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        tbl[7];
        int          base, n, idx;
        logic [31:0] rp;

        tbl[0] = '{pc: 32'd244, exp_pc: 32'd244, exp_halt: 1'b0};
        tbl[1] = '{pc: 32'd247, exp_pc: 32'd244, exp_halt: 1'b0};
        tbl[2] = '{pc: 32'd248, exp_pc: 32'd248, exp_halt: 1'b1};
        tbl[3] = '{pc: 32'd249, exp_pc: 32'd248, exp_halt: 1'b1};
        tbl[4] = '{pc: 32'd251, exp_pc: 32'd248, exp_halt: 1'b1};
        tbl[5] = '{pc: 32'd252, exp_pc: 32'd252, exp_halt: 1'b0};
        tbl[6] = '{pc: 32'h0000_10F8, exp_pc: 32'h0000_10F8, exp_halt: 1'b0};

        rst_i = 1'b1;
        bus.pc_valid_i = 1'b0; bus.pc_i = 32'd0; bus.flush_i = 1'b0; bus.inst_ready_i = 1'b0;
        bus.imem_gnt_i = 1'b0; bus.imem_rvalid_i = 1'b0; bus.imem_rdata_i = 32'd0;

        // halt-match vector table
        for (int i = 0; i < 7; i++) begin
            do_reset();
            bus.inst_ready_i = 1'b1;
            send_pc(tbl[i].pc);
            run(6);
            chk("tbl_halted", 32'(bus.halted_o), 32'(tbl[i].exp_halt));
            chk("tbl_pc", last_pop_pc, tbl[i].exp_pc);
        end

        // in-order delivery, request one cycle after acceptance
        do_reset();
        bus.inst_ready_i = 1'b1;
        base = dut_pops;
        send_pc(32'd0);
        chk("t1_req_latency", 32'(bus.imem_req_o), 32'd1);
        send_pc(32'd4);
        send_pc(32'd8);
        run(6);
        chk("t1_pops", 32'(dut_pops - base), 32'd3);
        chk("t1_last", last_pop_data, memf(32'd8));

        // stalled decode: four fills, then back-pressure
        do_reset();
        bus.inst_ready_i = 1'b0;
        base = dut_pops;
        dut_accs = 0;
        idx = 0;
        n = 0;
        bus.pc_valid_i = 1'b1;
        while (idx < 6 && n < 40) begin
            bus.pc_i = 32'h100 + 32'(4 * idx);
            step();
            if (last_acc) idx++;
            n++;
        end
        chk("t2_accepts", 32'(dut_accs), 32'd4);
        chk("t2_ready_full", 32'(bus.pc_ready_o), 32'd0);
        bus.inst_ready_i = 1'b1;
        n = 0;
        while (idx < 6 && n < 60) begin
            bus.pc_i = 32'h100 + 32'(4 * idx);
            step();
            if (last_acc) idx++;
            n++;
        end
        bus.pc_valid_i = 1'b0;
        if (idx < 6) fail_bound("t2_resume");
        run(8);
        chk("t2_pops", 32'(dut_pops - base), 32'd6);
        chk("t2_last_pc", last_pop_pc, 32'h114);

        // flush while waiting for data; late response must be drained
        do_reset();
        bus.inst_ready_i = 1'b1;
        rv_dly = 2;
        send_pc(32'h20);
        step();
        bus.flush_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        #1;
        chk("t3_drain_ready", 32'(bus.pc_ready_o), 32'd0);
        run(6);
        chk("t3_empty", 32'(bus.inst_valid_o), 32'd0);
        rv_dly = 0;
        send_pc(32'h40);
        run(5);
        chk("t3_pc", last_pop_pc, 32'h40);
        chk("t3_data", last_pop_data, memf(32'h40));

        // flush coincident with rvalid of the halt address and with a pop
        do_reset();
        bus.inst_ready_i = 1'b0;
        send_pc(32'h10);
        run(3);
        rv_dly = 2;
        send_pc(HALT);
        wait_rvalid("t4_rvalid");
        bus.flush_i = 1'b1;
        bus.inst_ready_i = 1'b1;
        step();
        bus.flush_i = 1'b0;
        bus.inst_ready_i = 1'b0;
        #1;
        chk("t4_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("t4_halted", 32'(bus.halted_o), 32'd0);
        chk("t4_ready", 32'(bus.pc_ready_o), 32'd1);

        // halt after 248, sticky until reset
        do_reset();
        bus.inst_ready_i = 1'b1;
        base = dut_pops;
        send_pc(32'd244);
        send_pc(HALT);
        wait_rvalid("t5_rvalid");
        step();
        chk("t5_halted", 32'(bus.halted_o), 32'd1);
        bus.pc_valid_i = 1'b1;
        bus.pc_i = 32'd0;
        run(5);
        chk("t5_ready", 32'(bus.pc_ready_o), 32'd0);
        chk("t5_req", 32'(bus.imem_req_o), 32'd0);
        chk("t5_pops", 32'(dut_pops - base), 32'd2);
        chk("t5_last_pc", last_pop_pc, HALT);
        bus.pc_valid_i = 1'b0;
        do_reset();
        chk("t5_cleared", 32'(bus.halted_o), 32'd0);

        // reset in REQ with grant held low
        gw = 4;
        send_pc(32'h30);
        chk("t6_req_before", 32'(bus.imem_req_o), 32'd1);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        #1;
        chk("t6_req", 32'(bus.imem_req_o), 32'd0);
        chk("t6_valid", 32'(bus.inst_valid_o), 32'd0);
        chk("t6_ready", 32'(bus.pc_ready_o), 32'd1);
        run(2);

        // randomized traffic with random grant/response latency and decode stalls
        do_reset();
        gnt_dly = -1;
        rv_dly = -1;
        last_acc = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if (!bus.pc_valid_i || last_acc) begin
                bus.pc_valid_i = ($urandom_range(9, 0) < 7);
                do begin
                    rp = {22'd0, 8'($urandom_range(255, 0)), 2'($urandom_range(3, 0))};
                end while ((rp & 32'hFFFF_FFFC) == HALT);
                bus.pc_i = rp;
            end
            bus.inst_ready_i = ($urandom_range(9, 0) < 6);
            step();
        end
        bus.pc_valid_i = 1'b0;
        bus.inst_ready_i = 1'b1;
        run(20);
        chk("rand_drained", 32'(bus.inst_valid_o), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
